sample_playback_reader: RTL



---
 rtl/sample_playback_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sample_playback_reader.sv
// Sequential sample-ROM reader: fetches one word at a time from the sample ROM,
// keeps a single prefetched word and hands it to the audio path on each
// sample_tick. Supports restart, stop, optional looping and underrun flagging.
module sample_playback_reader #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_WORDS  = 48384,
  parameter int unsigned START_ADDR = 0,
  parameter bit          LOOP       = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic                stop,
  input  logic                sample_tick,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  // Last address computed wide so an overflowing configuration is caught.
  localparam logic [63:0]       LAST_WIDE = 64'(START_ADDR) + 64'(NUM_WORDS) - 64'd1;
  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A    = LAST_WIDE[ADDR_W-1:0];

  if ((NUM_WORDS == 32'd0) || (LAST_WIDE >= (64'd1 << ADDR_W))) begin : g_bad_cfg
    $error("sample_playback_reader: playback range does not fit in ADDR_W");
  end

  logic [1:0]        state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] buf_r;
  logic              buf_last_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic              mem_chipselect_r;
  logic [DATA_W-1:0] sample_out_r;
  logic              sample_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              underrun_r;

  logic              last_word_s;
  logic [ADDR_W-1:0] ptr_next_s;
  logic              final_tick_s;

  // Address advance: wrap back to the first word after the last one.
  always_comb begin
    last_word_s  = (ptr_r == LAST_A);
    final_tick_s = buf_last_r & ~LOOP;
    if (last_word_s) begin
      ptr_next_s = START_A;
    end else begin
      ptr_next_s = ptr_r + ADDR_W'(1);
    end
  end

  // Playback FSM with registered bus strobes and sample outputs; stop beats trigger beats tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      ptr_r            <= START_A;
      buf_r            <= {DATA_W{1'b0}};
      buf_last_r       <= 1'b0;
      mem_address_r    <= {ADDR_W{1'b0}};
      mem_chipselect_r <= 1'b0;
      sample_out_r     <= {DATA_W{1'b0}};
      sample_valid_r   <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      underrun_r       <= 1'b0;
    end else begin
      sample_valid_r   <= 1'b0;
      done_r           <= 1'b0;
      mem_chipselect_r <= 1'b0;
      if (stop) begin
        state_r      <= ST_IDLE;
        busy_r       <= 1'b0;
        sample_out_r <= {DATA_W{1'b0}};
      end else if (trigger) begin
        // Restart from the top; any read still in flight is simply ignored.
        state_r          <= ST_FETCH;
        ptr_r            <= START_A;
        busy_r           <= 1'b1;
        underrun_r       <= 1'b0;
        mem_chipselect_r <= 1'b1;
        mem_address_r    <= START_A;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (sample_tick) begin
              sample_out_r <= {DATA_W{1'b0}};
            end
          end
          ST_FETCH: begin
            state_r <= ST_WAIT;
            if (sample_tick) begin
              underrun_r <= 1'b1;
            end
          end
          ST_WAIT: begin
            buf_r      <= mem_readdata;
            buf_last_r <= last_word_s;
            ptr_r      <= ptr_next_s;
            state_r    <= ST_FULL;
            if (sample_tick) begin
              underrun_r <= 1'b1;
            end
          end
          ST_FULL: begin
            if (sample_tick) begin
              sample_out_r   <= buf_r;
              sample_valid_r <= 1'b1;
              if (final_tick_s) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                state_r          <= ST_FETCH;
                mem_chipselect_r <= 1'b1;
                mem_address_r    <= ptr_r;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_address    = mem_address_r;
  assign mem_chipselect = mem_chipselect_r;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = {(DATA_W/8){1'b1}};
  assign sample_out     = sample_out_r;
  assign sample_valid   = sample_valid_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign underrun       = underrun_r;

endmodule
